// File: rtl/bus_arbiter_6502_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_6502_if
//   Signal bundle between the bus arbiter, the chip_6502 core, the DMA
//   fetcher and the synchronous RAM port.
//   master : arbiter view (drives phi, CPU return path, DMA return path, RAM)
//   slave  : environment view (CPU, DMA engine and RAM drive the rest)
//   CPU  : cpu_ab, cpu_rw, cpu_dbo -> ; <- cpu_dbi, cpu_rdy, phi
//   DMA  : dma_req, dma_addr -> ; <- dma_gnt, dma_valid, dma_data
//   RAM  : <- mem_addr, mem_we, mem_wdata ; mem_rdata ->
// ---------------------------------------------------------------------------
interface bus_arbiter_6502_if;
  logic        phi;
  logic [15:0] cpu_ab;
  logic        cpu_rw;
  logic [7:0]  cpu_dbo;
  logic [7:0]  cpu_dbi;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_gnt;
  logic        dma_valid;
  logic [7:0]  dma_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (
    input  cpu_ab, cpu_rw, cpu_dbo, dma_req, dma_addr, mem_rdata,
    output phi, cpu_dbi, cpu_rdy, dma_gnt, dma_valid, dma_data,
           mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output cpu_ab, cpu_rw, cpu_dbo, dma_req, dma_addr, mem_rdata,
    input  phi, cpu_dbi, cpu_rdy, dma_gnt, dma_valid, dma_data,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/bus_arbiter_6502.sv
// ---------------------------------------------------------------------------
// bus_arbiter_6502
//   Generates the 6502 phi clock from the FPGA clock and shares one
//   synchronous RAM port between the CPU and a DMA read requester. Every phi
//   period is one bus slot of 2*PHI_HALF clk cycles; the owner of a slot is
//   chosen on the last clk of phi low. A DMA slot stalls the CPU via cpu_rdy.
//   CPU write slots are never stolen, and after DMA_MAX_BURST consecutive DMA
//   slots one CPU slot is forced.
// Ports
//   clk : FPGA clock, rising edge
//   res : synchronous active-low reset
//   bus : bus_arbiter_6502_if.master (CPU, DMA and RAM signals)
// ---------------------------------------------------------------------------
module bus_arbiter_6502 #(
  parameter int unsigned PHI_HALF      = 5,
  parameter int unsigned DMA_MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      res,
  bus_arbiter_6502_if.master        bus
);

  localparam int unsigned SLOT = 2 * PHI_HALF;
  localparam int unsigned CW   = $clog2(SLOT);
  localparam int unsigned BW   = $clog2(DMA_MAX_BURST + 1);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  owner_t        r_owner;
  owner_t        w_owner_nxt;

  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_burst;
  logic          r_phi;
  logic          r_wr_slot;
  logic          r_cpu_rdy;
  logic [7:0]    r_cpu_dbi;
  logic          r_dma_gnt;
  logic          r_dma_valid;
  logic [7:0]    r_dma_data;
  logic [15:0]   r_mem_addr;
  logic          r_mem_we;
  logic [7:0]    r_mem_wdata;

  logic          w_decide;
  logic          w_latch_wd;
  logic          w_last;
  logic          w_dma_win;

  // Slot timing points, all evaluated on the current count; the registered
  // actions become visible one clk later.
  assign w_decide   = (r_cnt == CW'(PHI_HALF - 1));
  assign w_latch_wd = (r_cnt == CW'(SLOT - 2));
  assign w_last     = (r_cnt == CW'(SLOT - 1));

  // A CPU write cycle cannot be stretched, so DMA only wins read slots.
  assign w_dma_win  = bus.dma_req && bus.cpu_rw &&
                      (r_burst < BW'(DMA_MAX_BURST));

  // Owner FSM: only changes at the decision point and then holds until the
  // next one, so it stays valid across the wrap into the next phi-low phase.
  always_comb begin
    w_owner_nxt = r_owner;
    if (w_decide) begin
      w_owner_nxt = w_dma_win ? OWN_DMA : OWN_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_owner <= OWN_CPU;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_cnt       <= '0;
      r_burst     <= '0;
      r_phi       <= 1'b0;
      r_wr_slot   <= 1'b0;
      r_cpu_rdy   <= 1'b1;
      r_cpu_dbi   <= 8'hEA;
      r_dma_gnt   <= 1'b0;
      r_dma_valid <= 1'b0;
      r_dma_data  <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_cnt       <= w_last ? '0 : r_cnt + 1'b1;
      r_phi       <= (r_cnt >= CW'(PHI_HALF));
      r_mem_we    <= 1'b0;
      r_dma_valid <= 1'b0;

      if (w_decide) begin
        if (w_dma_win) begin
          r_cpu_rdy  <= 1'b0;
          r_dma_gnt  <= 1'b1;
          r_mem_addr <= bus.dma_addr;
          r_burst    <= r_burst + 1'b1;
          r_wr_slot  <= 1'b0;
        end else begin
          r_cpu_rdy  <= 1'b1;
          r_mem_addr <= bus.cpu_ab;
          r_burst    <= '0;
          r_wr_slot  <= ~bus.cpu_rw;
        end
      end

      // Data and strobe are registered together so the single-clk write
      // lands on the last clk of phi high with stable data.
      if (w_latch_wd && (r_owner == OWN_CPU) && r_wr_slot) begin
        r_mem_wdata <= bus.cpu_dbo;
        r_mem_we    <= 1'b1;
      end

      if (w_last) begin
        if (r_owner == OWN_DMA) begin
          r_dma_data  <= bus.mem_rdata;
          r_dma_valid <= 1'b1;
          r_dma_gnt   <= 1'b0;
        end else if (!r_wr_slot) begin
          r_cpu_dbi   <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.phi       = r_phi;
  assign bus.cpu_rdy   = r_cpu_rdy;
  assign bus.cpu_dbi   = r_cpu_dbi;
  assign bus.dma_gnt   = r_dma_gnt;
  assign bus.dma_valid = r_dma_valid;
  assign bus.dma_data  = r_dma_data;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
